ctrl_indicador: RTL
===================

CTRL_INDICADOR -- requirements
Module: ctrl_indicador

Interface
REQ-001 Parameter DEB_CYC, default 500000: consecutive stable cycles required to accept a new button level.
REQ-002 Parameter DIV_SCAN, default 50000: clock cycles per display digit slot.
REQ-003 Port clk  in  1  single system clock; all state on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port btn_up  in  1  raw asynchronous button, increment request.
REQ-006 Port btn_down  in  1  raw asynchronous button, decrement request.
REQ-007 Port n_3  in  1  thousands digit from frequency decoder.
REQ-008 Port n_2  in  3  hundreds digit from frequency decoder.
REQ-009 Port n_1  in  4  tens digit from frequency decoder.
REQ-010 Port n_0  in  3  units digit from frequency decoder.
REQ-011 Port indicador  out  3  registered frequency selection driving the decoder.
REQ-012 Port cambio  out  1  one-cycle pulse when indicador changes value.
REQ-013 Port an  out  4  active-low one-hot digit anode enables.
REQ-014 Port digito  out  4  BCD value of the currently enabled digit.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer before debouncing.
REQ-016 Debounced level SHALL take the synchronized level only after DEB_CYC consecutive cycles differing from the current debounced level; any mismatch-free cycle restarts the count.
REQ-017 A request SHALL be a debounced 0->1 transition; holding a button SHALL yield exactly one request.
REQ-018 Up request: indicador+1, saturating at 7; down request: indicador-1, saturating at 0; update on the edge after the request cycle.
REQ-019 Up and down requests in the same cycle SHALL be ignored (no change, no cambio).
REQ-020 cambio SHALL be 1 for exactly the cycle in which indicador holds its new value; never asserted at saturation.
REQ-021 Scan counter SHALL count 0..DIV_SCAN-1 and wrap; tick asserted when count = DIV_SCAN-1.
REQ-022 Digit FSM states D0,D1,D2,D3; on tick advance D0->D1->D2->D3->D0; otherwise hold.
REQ-023 an SHALL decode from the state register only: D0=1110, D1=1101, D2=1011, D3=0111.
REQ-024 digito SHALL be combinational: D0={0,n_0}, D1=n_1, D2={0,n_2}, D3={000,n_3}.
REQ-025 Button path and scan path SHALL be independent; a selection change SHALL NOT reset the scan.

Reset
REQ-026 On reset: indicador=0, cambio=0, state=D0, an=1110, scan count=0, synchronizers, debounce counters and debounced levels=0.
REQ-027 Reset mid-debounce SHALL discard the pending press; a button held through reset release SHALL be re-debounced and then produce one request.

Structure
REQ-028 Shared package ctrl_indicador_pkg SHALL hold digit-state encodings, anode patterns and IND_MAX=7.
REQ-029 Debouncer (synchronizer + counter + edge detect) SHALL be sub-module antirrebote, instantiated once per button.

Verification (bench uses DEB_CYC=4, DIV_SCAN=3)
REQ-030 Reset asserted 2 cycles -> indicador=0, an=1110, cambio=0, digito=n_0.
REQ-031 btn_up high 3 cycles then low, later high 12 cycles -> first no change; second indicador 0->1 once, one cambio pulse.
REQ-032 Eight separate up presses -> indicador 7 after seventh, eighth gives no change/no cambio; from 0 a down press gives no change.
REQ-033 btn_up and btn_down rise together, held 10 cycles -> indicador unchanged, cambio never 1.
REQ-034 n_0=5,n_1=9,n_2=3,n_3=1 -> an 1110,1101,1011,0111,1110 each held 3 cycles; digito 5,9,3,1 matching.
REQ-035 Reset pulsed 2 cycles into a btn_up press held 20 cycles -> indicador 0 after reset, then 1 exactly once after DEB_CYC+2 cycles.

Source files
------------

// File: rtl/ctrl_indicador_pkg.sv
// ctrl_indicador_pkg
//   Shared constants for the frequency-selection indicator controller:
//   digit-scan state encodings, the matching active-low anode patterns
//   and the top value of the selection register.
package ctrl_indicador_pkg;

   // Digit-scan FSM states (one per display digit)
   localparam logic [1:0] D0 = 2'd0;
   localparam logic [1:0] D1 = 2'd1;
   localparam logic [1:0] D2 = 2'd2;
   localparam logic [1:0] D3 = 2'd3;

   // Active-low one-hot anode enables for each state
   localparam logic [3:0] AN_D0 = 4'b1110;
   localparam logic [3:0] AN_D1 = 4'b1101;
   localparam logic [3:0] AN_D2 = 4'b1011;
   localparam logic [3:0] AN_D3 = 4'b0111;

   // Saturation limit of the selection register
   localparam logic [2:0] IND_MAX = 3'd7;

endpackage

// File: rtl/ctrl_indicador_antirrebote.sv
// antirrebote
//   Button conditioner: 2-flop synchronizer, counter debouncer and rising
//   edge detector. req_o pulses for one cycle per accepted press.
// Ports
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   btn_i   raw asynchronous button level
//   req_o   one-cycle request on a debounced 0->1 transition
module antirrebote #(
   parameter int unsigned DEB_CYC = 500000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic req_o
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic          deb_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles where the synchronized level disagrees with
   // the debounced one; any agreeing cycle drops the count back to zero.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (s2_q != deb_q) begin
         if (cnt_q == CW'(DEB_CYC - 1)) deb_d = s2_q;
         else                           cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= btn_i;
         s2_q       <= s1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
      end
   end

   assign req_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/ctrl_indicador.sv
// ctrl_indicador
//   Up/down frequency-selection register driven by two debounced buttons,
//   plus an independent 4-digit multiplexed display scanner.
// Ports
//   clk        system clock (rising edge)
//   reset      synchronous active-high reset
//   btn_up     raw increment button
//   btn_down   raw decrement button
//   n_3..n_0   BCD digits from the frequency decoder
//   indicador  registered selection (0..7)
//   cambio     one-cycle pulse while indicador shows a new value
//   an         active-low one-hot anode enables
//   digito     BCD value of the enabled digit
module ctrl_indicador
   import ctrl_indicador_pkg::*;
#(
   parameter int unsigned DEB_CYC  = 500000,
   parameter int unsigned DIV_SCAN = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       n_3,
   input  logic [2:0] n_2,
   input  logic [3:0] n_1,
   input  logic [2:0] n_0,
   output logic [2:0] indicador,
   output logic       cambio,
   output logic [3:0] an,
   output logic [3:0] digito
);

   localparam int unsigned SW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

   logic          up_req, down_req;
   logic [2:0]    ind_q, ind_d;
   logic          cambio_q, cambio_d;
   logic [SW-1:0] scan_q, scan_d;
   logic          tick;
   logic [1:0]    state_q, state_d;

   antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_up (
      .clk_i (clk),
      .rst_i (reset),
      .btn_i (btn_up),
      .req_o (up_req)
   );

   antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_down (
      .clk_i (clk),
      .rst_i (reset),
      .btn_i (btn_down),
      .req_o (down_req)
   );

   // Simultaneous up/down requests cancel; saturated moves raise no cambio.
   always_comb begin
      ind_d    = ind_q;
      cambio_d = 1'b0;
      if (up_req && !down_req && ind_q != IND_MAX) begin
         ind_d    = ind_q + 3'd1;
         cambio_d = 1'b1;
      end else if (down_req && !up_req && ind_q != 3'd0) begin
         ind_d    = ind_q - 3'd1;
         cambio_d = 1'b1;
      end
   end

   assign tick    = (scan_q == SW'(DIV_SCAN - 1));
   assign scan_d  = tick ? '0 : scan_q + 1'b1;
   assign state_d = tick ? state_q + 2'd1 : state_q;   // D3 wraps to D0

   always_ff @(posedge clk) begin
      if (reset) begin
         ind_q    <= 3'd0;
         cambio_q <= 1'b0;
         scan_q   <= '0;
         state_q  <= D0;
      end else begin
         ind_q    <= ind_d;
         cambio_q <= cambio_d;
         scan_q   <= scan_d;
         state_q  <= state_d;
      end
   end

   always_comb begin
      an     = AN_D0;
      digito = 4'd0;
      case (state_q)
         D0: begin an = AN_D0; digito = {1'b0, n_0};  end
         D1: begin an = AN_D1; digito = n_1;          end
         D2: begin an = AN_D2; digito = {1'b0, n_2};  end
         D3: begin an = AN_D3; digito = {3'b000, n_3}; end
         default: begin an = AN_D0; digito = 4'd0;   end
      endcase
   end

   assign indicador = ind_q;
   assign cambio    = cambio_q;

endmodule
